// File: rtl/scrambler_ctrl_pkg.sv
// scrambler_ctrl_pkg: shared state encoding and frame constants for the 802.11a scrambler sequencer.
package scrambler_ctrl_pkg;
    localparam int SERVICE_BITS = 16;
    localparam int TAIL_BITS    = 6;
    localparam int DEF_LEN_W    = 12;
    typedef enum logic [2:0] {
        ST_IDLE, ST_SEED, ST_WAIT_RDY, ST_SERVICE, ST_DATA, ST_TAIL, ST_PAD, ST_FIN
    } state_t;
endpackage

// File: rtl/scrambler_frame_ctrl_scrambler.sv
// scrambler: 802.11a x^7+x^4+1 additive scrambler, seeded on the first clock after reset release.
module scrambler (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seed,
    input  logic       run,
    input  logic       x,
    output logic       x_scrambled,
    output logic       valid,
    output logic       rdy
);
    logic [6:0] r_lfsr;
    logic       r_rdy, r_valid, r_xs;
    logic       w_fb;
    assign w_fb        = r_lfsr[6] ^ r_lfsr[3];
    assign x_scrambled = r_xs;
    assign valid       = r_valid;
    assign rdy         = r_rdy;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr  <= '0;
            r_rdy   <= 1'b0;
            r_valid <= 1'b0;
            r_xs    <= 1'b0;
        end else begin
            r_valid <= r_rdy & run;
            if (!r_rdy) begin
                r_lfsr <= seed;
                r_rdy  <= 1'b1;
            end else if (run) begin
                r_lfsr <= {r_lfsr[5:0], w_fb};
                r_xs   <= x ^ w_fb;
            end
        end
    end
endmodule

// File: rtl/scrambler_frame_ctrl.sv
// scrambler_frame_ctrl: sequences SERVICE, PSDU, TAIL and PAD bits through the scrambler for one frame.
module scrambler_frame_ctrl
    import scrambler_ctrl_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] psdu_len,
    input  logic [7:0]       n_dbps,
    input  logic [6:0]       seed,
    input  logic [7:0]       byte_data,
    input  logic             byte_valid,
    output logic             byte_rdy,
    output logic             out_bit,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy,
    output logic             done
);
    state_t           r_state;
    logic [LEN_W-1:0] r_len, r_byte_cnt;
    logic [7:0]       r_ndbps, r_sym, r_shift;
    logic [6:0]       r_seed;
    logic [2:0]       r_bit_idx;
    logic [4:0]       r_phase;
    logic             r_tag_tail, r_tag_last, r_busy, r_done;
    logic             w_run, w_x, w_wrap, w_tail, w_last, w_rdy, w_valid, w_xs, w_scr_rst_n;

    assign w_scr_rst_n = r_state != ST_SEED;
    assign byte_rdy    = r_state == ST_DATA && r_bit_idx == 3'd0;
    assign w_wrap      = r_sym == r_ndbps - 8'd1;
    assign w_tail      = r_state == ST_TAIL;
    assign w_last      = w_wrap && (r_state == ST_PAD || (w_tail && r_phase == 5'(TAIL_BITS - 1)));
    // The first SERVICE run is issued from WAIT_RDY as soon as the scrambler is seeded.
    assign w_run = (r_state == ST_WAIT_RDY) ? w_rdy :
                   byte_rdy ? byte_valid :
                   (r_state inside {ST_SERVICE, ST_DATA, ST_TAIL, ST_PAD});
    assign w_x   = r_state == ST_DATA && (byte_rdy ? byte_data[0] : r_shift[0]);

    assign out_bit   = w_xs & ~r_tag_tail;
    assign out_valid = w_valid;
    assign out_last  = r_tag_last;
    assign busy      = r_busy;
    assign done      = r_done;

    scrambler u_scr (
        .clk        (clk),
        .reset      (reset & w_scr_rst_n),
        .seed       (r_seed),
        .run        (w_run),
        .x          (w_x),
        .x_scrambled(w_xs),
        .valid      (w_valid),
        .rdy        (w_rdy)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_byte_cnt <= '0;
            r_ndbps    <= '0;
            r_sym      <= '0;
            r_shift    <= '0;
            r_seed     <= '0;
            r_bit_idx  <= '0;
            r_phase    <= '0;
            r_tag_tail <= 1'b0;
            r_tag_last <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done     <= r_state == ST_FIN;
            r_tag_tail <= w_run & w_tail;
            r_tag_last <= w_run & w_last;
            if (w_run) r_sym <= w_wrap ? 8'd0 : r_sym + 8'd1;
            case (r_state)
                ST_IDLE: if (start) begin
                    r_len      <= psdu_len;
                    r_ndbps    <= n_dbps;
                    r_seed     <= seed;
                    r_sym      <= '0;
                    r_byte_cnt <= '0;
                    r_bit_idx  <= '0;
                    r_phase    <= '0;
                    r_busy     <= 1'b1;
                    r_state    <= ST_SEED;
                end
                ST_SEED: r_state <= ST_WAIT_RDY;
                ST_WAIT_RDY: if (w_rdy) begin
                    r_phase <= 5'd1;
                    r_state <= ST_SERVICE;
                end
                ST_SERVICE: if (r_phase == 5'(SERVICE_BITS - 1)) begin
                    r_phase <= '0;
                    r_state <= (r_len == '0) ? ST_TAIL : ST_DATA;
                end else r_phase <= r_phase + 5'd1;
                ST_DATA: if (w_run) begin
                    r_bit_idx <= r_bit_idx + 3'd1;
                    r_shift   <= byte_rdy ? {1'b0, byte_data[7:1]} : r_shift >> 1;
                    if (r_bit_idx == 3'd7) begin
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        if (r_byte_cnt == r_len - 1'b1) r_state <= ST_TAIL;
                    end
                end
                ST_TAIL: if (r_phase == 5'(TAIL_BITS - 1)) begin
                    r_phase <= '0;
                    r_state <= w_wrap ? ST_FIN : ST_PAD;
                end else r_phase <= r_phase + 5'd1;
                ST_PAD: if (w_wrap) r_state <= ST_FIN;
                ST_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scrambler_frame_ctrl.sv
// tb_scrambler_frame_ctrl: frame-level checks of the scrambler sequencer against a sequence-recurrence model.
module tb_scrambler_frame_ctrl;
    localparam int LW = 12;
    logic          clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [LW-1:0] psdu_len = '0;
    logic [7:0]    n_dbps = 8'd24, byte_data = '0;
    logic [6:0]    seed = 7'd1;
    logic          byte_valid = 1'b0;
    logic          byte_rdy, out_bit, out_valid, out_last, busy, done;
    int            total = 0, bad = 0;
    logic [7:0]    mem [0:4095];

    typedef struct {
        int         len;
        int         nd;
        logic [6:0] sd;
        bit         rnd;
        int         sb;
        int         sn;
        int         tot;
    } vec_t;
    vec_t tbl [7];

    scrambler_frame_ctrl #(.LEN_W(LW)) dut (
        .clk(clk), .reset(reset), .start(start), .psdu_len(psdu_len), .n_dbps(n_dbps),
        .seed(seed), .byte_data(byte_data), .byte_valid(byte_valid), .byte_rdy(byte_rdy),
        .out_bit(out_bit), .out_valid(out_valid), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit want_valid(int bi, int len, int sb, int stalls, int sn);
        return bi < len && !(bi == sb && stalls < sn);
    endfunction

    task automatic run_frame(input int len, input int nd, input logic [6:0] sd, input bit rnd,
                             input int sb, input int sn, input int exp_tot, input string tag,
                             output logic [15:0] first16);
        bit s[$], expq[$], got[$];
        int tot_model, k, first_k, prev_k, last_k, done_k, n_last, last_idx, n_hs, bi, stalls, gaps, mism, tail_ones;
        bit hs, fin, bz, d;
        for (int i = 0; i < len; i++) mem[i] = rnd ? 8'($urandom) : 8'h00;
        tot_model = nd * ((22 + 8 * len + nd - 1) / nd);
        // Scrambler output obeys s[n] = s[n-7] ^ s[n-4]; the seed supplies the seven bits of history.
        for (int i = 0; i < 7; i++) s.push_back(sd[6 - i]);
        for (int i = 0; i < tot_model; i++) s.push_back(s[i] ^ s[i + 3]);
        for (int p = 0; p < tot_model; p++) begin
            d = (p >= 16 && p < 16 + 8 * len) ? mem[(p - 16) / 8][(p - 16) % 8] : 1'b0;
            expq.push_back((p >= 16 + 8 * len && p < 22 + 8 * len) ? 1'b0 : d ^ s[p + 7]);
        end
        {k, first_k, prev_k, last_k, done_k, n_last, last_idx, n_hs, bi, stalls, gaps} = {-1, -1, -1, -1, -1, 0, -1, 0, 0, 0, 0};
        fin = 0; bz = 1;
        @(posedge clk); #1;
        psdu_len = LW'(len); n_dbps = 8'(nd); seed = sd; start = 1'b1;
        byte_valid = want_valid(bi, len, sb, stalls, sn);
        byte_data = mem[0];
        @(posedge clk); #1;
        start = 1'b0; psdu_len = LW'($urandom); seed = 7'($urandom) | 7'd1;
        k = 0;
        while (!fin && k < exp_tot + sn + 40) begin
            @(negedge clk);
            if (k == 0) chk({tag, " busy after start"}, busy, 1);
            if (out_valid) begin
                if (first_k < 0) first_k = k;
                else if (k - prev_k > 1) gaps += k - prev_k - 1;
                prev_k = k;
                got.push_back(out_bit);
                if (out_last) begin n_last++; last_idx = got.size(); last_k = k; end
            end
            if (done) begin done_k = k; fin = 1; bz = busy; end
            hs = byte_rdy && byte_valid;
            if (hs) n_hs++;
            if (byte_rdy && !byte_valid && bi == sb) stalls++;
            @(posedge clk); #1;
            if (hs) bi++;
            start = (k == 10);
            byte_valid = want_valid(bi, len, sb, stalls, sn);
            byte_data = (bi < len) ? mem[bi] : 8'($urandom);
            k++;
        end
        start = 1'b0; byte_valid = 1'b0;
        mism = 0; tail_ones = 0;
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            if (got[i] != expq[i]) mism++;
            if (i >= 16 + 8 * len && i < 22 + 8 * len && got[i]) tail_ones++;
        end
        first16 = '0;
        for (int i = 0; i < 16 && i < got.size(); i++) first16 = {first16[14:0], got[i]};
        chk({tag, " timeout"}, fin, 1);
        chk({tag, " first valid cycle"}, first_k, 3);
        chk({tag, " bit count"}, got.size(), exp_tot);
        chk({tag, " last count"}, n_last, 1);
        chk({tag, " last index"}, last_idx, exp_tot);
        chk({tag, " done delay"}, done_k - last_k, 1);
        chk({tag, " busy at done"}, bz, 0);
        chk({tag, " handshakes"}, n_hs, len);
        chk({tag, " valid gap"}, gaps, sn);
        chk({tag, " tail ones"}, tail_ones, 0);
        chk({tag, " bit mismatches"}, mism, 0);
    endtask

    initial begin
        logic [15:0] f16;
        int          nds [8] = '{24, 36, 48, 72, 96, 144, 192, 216};
        int          len, nd, sb, sn;
        tbl[0] = '{1, 24, 7'h7F, 0, 0, 0, 48};
        tbl[1] = '{0, 24, 7'h5D, 1, 0, 0, 24};
        tbl[2] = '{100, 216, 7'h2A, 1, 0, 0, 864};
        tbl[3] = '{8, 48, 7'h11, 1, 3, 5, 96};
        tbl[4] = '{3, 36, 7'h01, 1, 0, 0, 72};
        tbl[5] = '{12, 144, 7'h6C, 1, 5, 2, 144};
        tbl[6] = '{2, 192, 7'h33, 1, 1, 3, 192};
        #2;
        chk("reset outputs", {byte_rdy, out_bit, out_valid, out_last, busy, done}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle outputs", {byte_rdy, out_valid, out_last, busy, done}, 0);
        for (int i = 0; i < 7; i++) begin
            run_frame(tbl[i].len, tbl[i].nd, tbl[i].sd, tbl[i].rnd, tbl[i].sb, tbl[i].sn, tbl[i].tot,
                      $sformatf("vec%0d", i), f16);
            if (i == 0) chk("seed 7F service bits", f16, 16'b0000111011110010);
        end
        @(posedge clk); #1;
        psdu_len = 20; n_dbps = 48; seed = 7'h45; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; byte_valid = 1'b1; byte_data = 8'hA5;
        repeat (60) @(negedge clk);
        chk("busy before abort", busy, 1);
        reset = 1'b0;
        #1 chk("abort outputs", {byte_rdy, out_bit, out_valid, out_last, busy, done}, 0);
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("held reset outputs", {byte_rdy, out_bit, out_valid, out_last, busy, done}, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("post abort idle", {byte_rdy, out_valid, out_last, busy, done}, 0);
        run_frame(20, 48, 7'h45, 1, 0, 0, 192, "restart", f16);
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(0, 30);
            nd = nds[$urandom_range(0, 7)];
            sb = (len > 0) ? $urandom_range(0, len - 1) : 0;
            sn = (len > 0) ? $urandom_range(0, 4) : 0;
            run_frame(len, nd, 7'($urandom_range(1, 127)), 1, sb, sn, nd * ((22 + 8 * len + nd - 1) / nd),
                      $sformatf("rnd%0d", r), f16);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scrambler_frame_ctrl.md
# scrambler_frame_ctrl

Frame sequencer for the 802.11a transmit scrambler. On a start pulse, it does the following:
- re-seeds an internal `scrambler` instance;
- feeds it the 16 SERVICE bits, the PSDU bits (pulled byte-wise through a valid/ready handshake), the 6 TAIL bits and the pad bits up to a whole number of OFDM symbols;
- emits the scrambled serial stream with the tail bits forced to zero, ready for the convolutional encoder.

## Interface
- `LEN_W`, 12: width of the PSDU length in bytes (max 4095).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle frame-start pulse; sampled only in IDLE.
- `psdu_len`  in  LEN_W  PSDU length in bytes; latched on accepted `start`.
- `n_dbps`  in  8  data bits per OFDM symbol (24, 36, 48, 72, 96, 144, 192, 216); latched on `start`.
- `seed`  in  7  scrambler seed, must be non-zero; latched on `start`.
- `byte_data`  in  8  PSDU byte, transmitted LSB first.
- `byte_valid`  in  1  `byte_data` is valid.
- `byte_rdy`  out  1  the controller takes `byte_data` this cycle.
- `out_bit`  out  1  scrambled bit.
- `out_valid`  out  1  `out_bit` is valid this cycle.
- `out_last`  out  1  final bit of the frame; asserted together with `out_valid`.
- `busy`  out  1  high from accepted `start` until `done`.
- `done`  out  1  one-cycle pulse in the cycle after `out_last`.

## Operation
- **Reset values:** all outputs are 0, the state is IDLE and all counters are 0.
- **States:** IDLE, SEED, WAIT_RDY, SERVICE, DATA, TAIL, PAD, FIN.
- **IDLE:** on `start`, latch `psdu_len`, `n_dbps` and `seed`, then go to SEED.
  - A `start` received in any other state is ignored.
- **SEED (1 cycle):** drive the internal scrambler reset low, i.e. `u_scr.reset = reset & scr_rst_n`. The scrambler's initial state is held at the latched seed. Go to WAIT_RDY.
- **WAIT_RDY:** wait for scrambler `rdy` = 1, then go to SERVICE.
- **SERVICE:** 16 runs with x = 0.
  - If `psdu_len` = 0, go from SERVICE directly to TAIL.
- **DATA:** 8·`psdu_len` runs.
  - When the bit index is 0: `byte_rdy` = 1 and run = `byte_valid`. The bit fed is `byte_data[0]`, and on handshake the byte is latched into a shift register.
  - Bit indices 1–7: run = 1, fed from the shift register, LSB first.
  - `byte_valid` low at index 0 stalls the frame. There are no runs and no counter advances, and the stall may last any number of cycles.
- **TAIL:** 6 runs with x = 0. The corresponding outputs are forced to 0 regardless of scrambler output.
- **PAD:** runs with x = 0 until the symbol-bit counter wraps to 0.
  - If the counter is already 0 at the end of TAIL, PAD is skipped.
- **Symbol-bit counter:** counts every run 0 … `n_dbps`−1, then wraps. Total bits = `n_dbps`·ceil((22 + 8·`psdu_len`)/`n_dbps`). No divider is used.
- **Output pipeline:** the scrambler output lands one cycle after its run.
  - A 1-cycle tag pipeline carries {is_tail, is_last} alongside each run.
  - `out_valid` = scrambler `valid`.
  - `out_bit` = `x_scrambled` & ~is_tail.
  - `out_last` = is_last.
- **FIN:** pulse `done`, deassert `busy`, return to IDLE.
- **Reset mid-frame:** immediate abort. All outputs return to 0 and no `done` is issued.

## Timing
- `start` sampled at edge E0 → SEED after E0, WAIT_RDY after E1.
- Scrambler `rdy` rises after E2. The first SERVICE run is in the cycle after E2, and the first `out_valid` is in the cycle after E3.
- Latency from run to `out_valid` is exactly 1 cycle. Without stalls, `out_valid` is continuous for the whole frame.
- `byte_rdy` is combinational from state and bit index. It does not depend on `byte_valid`.
- `done` follows `out_last` by exactly 1 cycle. A new `start` is accepted in the cycle after `done`.

## Structure
- Shared package `scrambler_ctrl_pkg`:
  - state enum;
  - `SERVICE_BITS` = 16;
  - `TAIL_BITS` = 6;
  - `LEN_W` default.
- One sub-module: the existing `scrambler`, instantiated as `u_scr`.
- Counters:
  - byte counter, LEN_W bits;
  - bit index, 3 bits;
  - phase counter, 5 bits;
  - symbol counter, 8 bits.

## Test plan
- **Seed response:** `seed` = 7'h7F, `psdu_len` = 1, byte 0x00, `n_dbps` = 24.
  - The first 16 outputs are 0000111011110010, the scrambler sequence.
  - 48 bits total and 18 pad bits; `out_last` on bit 48; `done` one cycle later.
- **Empty PSDU:** `psdu_len` = 0, `n_dbps` = 24 → 24 bits total (16 + 6 + 2 pad); bits 17–22 are 0.
- **Byte count and padding:** `psdu_len` = 100, `n_dbps` = 216, random bytes.
  - `byte_rdy` handshakes = 100; 864 bits total with 42 pad.
  - Output matches a reference model of scramble-then-zero-tail.
- **Stall:** `byte_valid` held low for 5 cycles at byte 3 → `out_valid` gap of exactly 5 cycles, with no bit lost or duplicated.
- **Reset and restart:** `reset` low mid-DATA → all outputs 0 and IDLE. The next `start` produces a full, correct frame.
- **Busy rejection:** `start` pulsed while `busy` is ignored; `psdu_len` and `seed` changes during the frame have no effect.
